// File: rtl/io_dir_router.sv
// Bidirectional pad router: a held ctrl pattern switches the uio pads between listen and drive, with a tri-stated turnaround between them.
// Optional feature: define TURN_COUNT_EN to count completed LISTEN->DRIVE entries on turn_count.
module io_dir_router #(
    parameter int            W        = 8,
    parameter int            CW       = 4,
    parameter logic [CW-1:0] MATCH    = 4'hF,
    parameter int            HOLD_CYC = 4,
    parameter int            DEAD_CYC = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic [CW-1:0] ctrl,
    input  logic [W-1:0]  din,
    input  logic [W-1:0]  pad_in,
    output logic [W-1:0]  pad_out,
    output logic [W-1:0]  pad_oe,
    output logic [W-1:0]  dout,
    output logic          drive_active,
    output logic          busy,
    output logic [7:0]    turn_count
);

    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam int DW = $clog2(DEAD_CYC + 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYC);
    localparam logic [DW-1:0] DEAD_INIT = DW'(DEAD_CYC - 1);

    typedef enum logic [1:0] {
        LISTEN   = 2'd0,
        TURN_ON  = 2'd1,
        DRIVE    = 2'd2,
        TURN_OFF = 2'd3
    } state_t;

    state_t        state;
    logic [HW-1:0] hold_cnt;
    logic [DW-1:0] dead_cnt;
    logic          req;

    // req comes straight from the register so a single glitchy ctrl sample can never start a turn
    always_comb begin
        req = (hold_cnt == HOLD_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (ena) begin
            if (ctrl != MATCH)
                hold_cnt <= '0;
            else if (hold_cnt != HOLD_MAX)
                hold_cnt <= hold_cnt + HW'(1);
        end
    end

    // Outputs are decoded from the next state, so every registered output lines up with state
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= LISTEN;
            dead_cnt     <= '0;
            pad_out      <= '0;
            pad_oe       <= '0;
            dout         <= '0;
            drive_active <= 1'b0;
            busy         <= 1'b0;
`ifdef TURN_COUNT_EN
            turn_count   <= 8'h00;
`endif
        end else if (ena) begin
            pad_out      <= '0;
            pad_oe       <= '0;
            dout         <= '0;
            drive_active <= 1'b0;
            busy         <= 1'b0;
            case (state)
                LISTEN: begin
                    if (req) begin
                        state    <= TURN_ON;
                        dead_cnt <= DEAD_INIT;
                        busy     <= 1'b1;
                    end else begin
                        dout <= pad_in;
                    end
                end
                TURN_ON: begin
                    if (dead_cnt != '0) begin
                        dead_cnt <= dead_cnt - DW'(1);
                        busy     <= 1'b1;
                    end else if (req) begin
                        state        <= DRIVE;
                        pad_oe       <= '1;
                        pad_out      <= din;
                        dout         <= din;
                        drive_active <= 1'b1;
`ifdef TURN_COUNT_EN
                        if (turn_count != 8'hFF)
                            turn_count <= turn_count + 8'd1;
`endif
                    end else begin
                        state <= LISTEN;
                        dout  <= pad_in;
                    end
                end
                DRIVE: begin
                    if (!req) begin
                        state    <= TURN_OFF;
                        dead_cnt <= DEAD_INIT;
                        busy     <= 1'b1;
                    end else begin
                        pad_oe       <= '1;
                        pad_out      <= din;
                        dout         <= din;
                        drive_active <= 1'b1;
                    end
                end
                TURN_OFF: begin
                    // req is deliberately ignored until the pads have been quiet for the full turnaround
                    if (dead_cnt != '0) begin
                        dead_cnt <= dead_cnt - DW'(1);
                        busy     <= 1'b1;
                    end else begin
                        state <= LISTEN;
                        dout  <= pad_in;
                    end
                end
                default: begin
                    state    <= LISTEN;
                    dead_cnt <= '0;
                end
            endcase
        end
    end

`ifndef TURN_COUNT_EN
    assign turn_count = 8'h00;
`endif

endmodule
